// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: sequences the shared memory/ALU datapath through
// fetch, decode, execute, memory and writeback steps, stalling on memory wait states.
module mips_mc_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       branch,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11,
      S_ERROR    = 4'd15
   } state_t;

   state_t state_q, state_d;
   logic   reg_write_c, mem_write_c;

   // State register; async reset aborts any instruction straight back to FETCH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next-state and Moore output decode
   always_comb begin
      state_d     = state_q;
      mem_req     = 1'b0;
      iord        = 1'b0;
      mem_write_c = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write_c = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      branch      = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'b00;
      illegal_op  = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEXEC;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_ERROR;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write_c = 1'b1;
            mem_to_reg  = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEMWR: begin
            mem_req     = 1'b1;
            iord        = 1'b1;
            mem_write_c = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_c = 1'b1;
            reg_dst     = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            branch    = 1'b1;
            pc_src    = 2'b01;
            state_d   = S_FETCH;
         end
         S_ADDIEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = S_FETCH;
         end
         default: begin
            // ERROR and the unused codes 12-14 all park here until reset
            illegal_op = 1'b1;
            state_d    = S_ERROR;
         end
      endcase
   end

   // Architectural writes are blocked for the whole reset pulse
   assign reg_write = reg_write_c & rst_n;
   assign mem_write = mem_write_c & rst_n;
   assign state     = 4'(state_q);

endmodule
